// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier operand sequencer: FSM encoding,
// default sizing, and state-classification helpers used by the output logic.
package mul_pkg;

    localparam int MUL_WIDTH_DEF = 16;
    localparam int MUL_DEPTH_DEF = 2;
    localparam int MUL_CNT_W     = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_A    = 3'd1,
        ST_LOAD_B    = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RELEASE   = 3'd4
    } mul_state_e;

    // The multiplier controller sees start held from the first operand beat
    // until completion is acknowledged.
    function automatic logic drives_start(input mul_state_e st);
        return (st == ST_LOAD_A) || (st == ST_LOAD_B) || (st == ST_WAIT_DONE);
    endfunction

    function automatic logic drives_operand_b(input mul_state_e st);
        return (st == ST_LOAD_B) || (st == ST_WAIT_DONE);
    endfunction

endpackage

// File: rtl/mul_pair_fifo.sv
// Operand-pair FIFO, DEPTH entries of {a,b}; pop data is the registered head.
// push_rdy is !full from registered occupancy only (no pop pass-through).
module mul_pair_fifo
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH_DEF,
    parameter int DEPTH = MUL_DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push_vld,
    output logic                 push_rdy,
    input  logic [2*WIDTH-1:0]   push_dat,
    output logic                 pop_vld,
    input  logic                 pop_rdy,
    output logic [2*WIDTH-1:0]   pop_dat
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [2*WIDTH-1:0] mem_q [DEPTH];
    logic [2*WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               push_fire;
    logic               pop_fire;

    assign push_rdy  = (cnt_q != CNT_W'(DEPTH));
    assign pop_vld   = (cnt_q != '0);
    assign pop_dat   = mem_q[rd_ptr_q];
    assign push_fire = push_vld && push_rdy;
    assign pop_fire  = pop_rdy && pop_vld;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_fire) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_fire, pop_fire})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/mul_operand_sequencer.sv
// Queues {a,b} pairs and serialises each onto mul_data (a, then b) under mul_start.
// First LOAD_A two cycles after a push into an idle, empty block; in_ready = FIFO not full.
module mul_operand_sequencer
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH_DEF,
    parameter int DEPTH = MUL_DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 mul_start,
    output logic [WIDTH-1:0]     mul_data,
    input  logic                 mul_done,
    output logic                 busy,
    output logic [MUL_CNT_W-1:0] issued_count
);

    mul_state_e             state_q, state_d;
    logic [WIDTH-1:0]       hold_a_q, hold_a_d;
    logic [WIDTH-1:0]       hold_b_q, hold_b_d;
    logic                   mul_start_q, mul_start_d;
    logic [WIDTH-1:0]       mul_data_q, mul_data_d;
    logic [MUL_CNT_W-1:0]   issued_count_q, issued_count_d;

    logic                   fifo_pop_vld;
    logic                   fifo_pop_rdy;
    logic [2*WIDTH-1:0]     fifo_pop_dat;

    mul_pair_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_pair_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (in_valid),
        .push_rdy (in_ready),
        .push_dat ({in_a, in_b}),
        .pop_vld  (fifo_pop_vld),
        .pop_rdy  (fifo_pop_rdy),
        .pop_dat  (fifo_pop_dat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            hold_a_q       <= '0;
            hold_b_q       <= '0;
            mul_start_q    <= 1'b0;
            mul_data_q     <= '0;
            issued_count_q <= '0;
        end else begin
            state_q        <= state_d;
            hold_a_q       <= hold_a_d;
            hold_b_q       <= hold_b_d;
            mul_start_q    <= mul_start_d;
            mul_data_q     <= mul_data_d;
            issued_count_q <= issued_count_d;
        end
    end

    // A done level still high from the previous operation must not launch
    // the next one, so IDLE waits for mul_done to drop before popping.
    always_comb begin
        state_d        = state_q;
        hold_a_d       = hold_a_q;
        hold_b_d       = hold_b_q;
        issued_count_d = issued_count_q;
        fifo_pop_rdy   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fifo_pop_vld && !mul_done) begin
                    state_d      = ST_LOAD_A;
                    fifo_pop_rdy = 1'b1;
                    hold_a_d     = fifo_pop_dat[2*WIDTH-1:WIDTH];
                    hold_b_d     = fifo_pop_dat[WIDTH-1:0];
                end
            end
            ST_LOAD_A:    state_d = ST_LOAD_B;
            ST_LOAD_B:    state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (mul_done) begin
                    state_d        = ST_RELEASE;
                    issued_count_d = issued_count_q + MUL_CNT_W'(1);
                end
            end
            ST_RELEASE:   state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        mul_start_d = drives_start(state_d);
        mul_data_d  = '0;
        if (state_d == ST_LOAD_A) begin
            mul_data_d = hold_a_d;
        end else if (drives_operand_b(state_d)) begin
            mul_data_d = hold_b_d;
        end
    end

    assign mul_start    = mul_start_q;
    assign mul_data     = mul_data_q;
    assign busy         = (state_q != ST_IDLE);
    assign issued_count = issued_count_q;

endmodule

// File: tb/tb_mul_operand_sequencer.sv
// Directed-plus-random bench for mul_operand_sequencer; expected operands come
// from an in-order queue of accepted pairs, occupancy from its size.
module tb_mul_operand_sequencer;

    localparam int W = 16;
    localparam int D = 2;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } pair_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         mul_start;
    logic [W-1:0] mul_data;
    logic         mul_done = 1'b0;
    logic         busy;
    logic [7:0]   issued_count;

    int           n_cmp = 0;
    int           n_err = 0;
    int           cyc = 0;
    int           exp_cnt = 0;
    pair_t        ref_q[$];
    pair_t        cur;

    always #5 clk = ~clk;

    mul_operand_sequencer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .mul_start    (mul_start),
        .mul_data     (mul_data),
        .mul_done     (mul_done),
        .busy         (busy),
        .issued_count (issued_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_rdy();
        return (ref_q.size() < D) ? 32'd1 : 32'd0;
    endfunction

    task automatic push_one(input logic [W-1:0] a, input logic [W-1:0] b);
        pair_t p;
        p.a = a;
        p.b = b;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        chk("push_rdy", 32'(in_ready), model_rdy());
        tick();
        ref_q.push_back(p);
        in_valid = 1'b0;
    endtask

    task automatic wait_load(output int n);
        n = 0;
        while (mul_start !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        if (mul_start !== 1'b1) chk("load_timeout", 32'(mul_start), 32'd1);
    endtask

    task automatic take_head();
        cur = ref_q.pop_front();
    endtask

    // Ends on the first WAIT_DONE sample.
    task automatic start_op(output int lat);
        wait_load(lat);
        take_head();
        chk("load_a_start", 32'(mul_start), 32'd1);
        chk("load_a_dat", 32'(mul_data), 32'(cur.a));
        chk("load_busy", 32'(busy), 32'd1);
        tick();
        chk("load_b_start", 32'(mul_start), 32'd1);
        chk("load_b_dat", 32'(mul_data), 32'(cur.b));
        tick();
        chk("wait_start", 32'(mul_start), 32'd1);
        chk("wait_dat", 32'(mul_data), 32'(cur.b));
    endtask

    // Starts on a WAIT_DONE sample, ends on the IDLE sample after RELEASE.
    task automatic finish_op(input int extra, input bit hold_done);
        for (int i = 0; i < extra; i++) begin
            tick();
            chk("wait_hold_start", 32'(mul_start), 32'd1);
            chk("wait_hold_dat", 32'(mul_data), 32'(cur.b));
            chk("wait_cnt", 32'(issued_count), 32'(exp_cnt));
        end
        mul_done = 1'b1;
        tick();
        exp_cnt = (exp_cnt + 1) % 256;
        chk("rel_start", 32'(mul_start), 32'd0);
        chk("rel_dat", 32'(mul_data), 32'd0);
        chk("rel_busy", 32'(busy), 32'd1);
        chk("rel_cnt", 32'(issued_count), 32'(exp_cnt));
        if (!hold_done) mul_done = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_start", 32'(mul_start), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int t1;
        int t2;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_start", 32'(mul_start), 32'd0);
        chk("rst_data", 32'(mul_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cnt", 32'(issued_count), 32'd0);
        rst = 1'b0;
        tick();

        // Single pair (17,5); the push cycle counts as cycle 0, LOAD_A is cycle 2
        push_one(16'd17, 16'd5);
        chk("push_idle_start", 32'(mul_start), 32'd0);
        start_op(lat);
        chk("first_load_lat", 32'(lat), 32'd1);
        finish_op(0, 1'b0);

        // Full FIFO while WAIT_DONE is stalled
        push_one(W'($urandom), W'($urandom));
        start_op(lat);
        push_one(W'($urandom), W'($urandom));
        push_one(W'($urandom), W'($urandom));
        chk("full_rdy", 32'(in_ready), model_rdy());
        ra = W'($urandom);
        rb = W'($urandom);
        in_valid = 1'b1;
        in_a = ra;
        in_b = rb;
        tick();
        chk("full_hold_rdy", 32'(in_ready), model_rdy());
        chk("full_wait_start", 32'(mul_start), 32'd1);
        mul_done = 1'b1;
        tick();
        exp_cnt = (exp_cnt + 1) % 256;
        chk("full_rel_cnt", 32'(issued_count), 32'(exp_cnt));
        chk("full_rel_rdy", 32'(in_ready), model_rdy());
        mul_done = 1'b0;
        tick();
        chk("full_idle_rdy", 32'(in_ready), model_rdy());
        tick();
        take_head();
        chk("full_pop_dat_a", 32'(mul_data), 32'(cur.a));
        chk("full_pop_rdy", 32'(in_ready), model_rdy());
        tick();
        ref_q.push_back('{a: ra, b: rb});
        in_valid = 1'b0;
        chk("full_pop_dat_b", 32'(mul_data), 32'(cur.b));
        tick();
        chk("full_wait_dat", 32'(mul_data), 32'(cur.b));
        finish_op(1, 1'b0);
        start_op(lat);
        finish_op(0, 1'b0);
        start_op(lat);
        finish_op(2, 1'b0);
        chk("full_drained_rdy", 32'(in_ready), model_rdy());

        // Back-to-back (3,4),(6,7), done after one WAIT_DONE cycle
        push_one(16'd3, 16'd4);
        push_one(16'd6, 16'd7);
        start_op(lat);
        t1 = cyc - 2;
        finish_op(0, 1'b0);
        start_op(lat);
        t2 = cyc - 2;
        chk("b2b_gap", 32'(t2 - t1), 32'd5);
        finish_op(0, 1'b0);

        // Stuck done: level held through RELEASE blocks the next issue
        push_one(W'($urandom), W'($urandom));
        start_op(lat);
        push_one(W'($urandom), W'($urandom));
        finish_op(0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stuck_idle_busy", 32'(busy), 32'd0);
            chk("stuck_idle_start", 32'(mul_start), 32'd0);
        end
        mul_done = 1'b0;
        start_op(lat);
        chk("stuck_release_lat", 32'(lat), 32'd1);
        finish_op(0, 1'b0);

        // Reset during WAIT_DONE with a pair queued
        push_one(W'($urandom), W'($urandom));
        start_op(lat);
        push_one(W'($urandom), W'($urandom));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ref_q.delete();
        exp_cnt = 0;
        chk("midrst_in_ready", 32'(in_ready), model_rdy());
        chk("midrst_start", 32'(mul_start), 32'd0);
        chk("midrst_data", 32'(mul_data), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_cnt", 32'(issued_count), 32'(exp_cnt));
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("post_rst_no_issue", 32'(mul_start), 32'd0);
        end

        // Count wrap over 256 random operations, some with b == 0
        for (int i = 0; i < 256; i++) begin
            ra = W'($urandom);
            rb = ((i % 4) == 0) ? '0 : W'($urandom);
            push_one(ra, rb);
            start_op(lat);
            finish_op(int'($urandom_range(0, 2)), 1'b0);
        end
        chk("wrap_cnt", 32'(issued_count), 32'(exp_cnt));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mul_operand_sequencer.md
MUL_OPERAND_SEQUENCER -- requirements
Module: mul_operand_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand and data bus width.
REQ-002 SHALL have parameter DEPTH, default 2: operand-pair FIFO entries, power of two, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: upstream operand pair is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the pair FIFO can accept a pair.
REQ-007 SHALL have port in_a, input, WIDTH bits: multiplicand.
REQ-008 SHALL have port in_b, input, WIDTH bits: multiplier (repeat count).
REQ-009 SHALL have port mul_start, output, 1 bit: start to the downstream multiplier controller.
REQ-010 SHALL have port mul_data, output, WIDTH bits: serial operand bus to the multiplier datapath.
REQ-011 SHALL have port mul_done, input, 1 bit: multiplier completion, level-sensitive.
REQ-012 SHALL have port busy, output, 1 bit: the FSM is not in IDLE.
REQ-013 SHALL have port issued_count, output, 8 bits: number of completed multiplications.

Function
REQ-014 SHALL accept a pair on a rising edge where in_valid && in_ready; in_ready SHALL equal !full, registered occupancy only, with no same-cycle pop pass-through.
REQ-015 SHALL store pairs in a DEPTH-entry FIFO; pointers SHALL wrap modulo DEPTH; occupancy counter SHALL be log2(DEPTH)+1 bits.
REQ-016 SHALL update occupancy correctly on a simultaneous push and pop: the count is unchanged.
REQ-017 SHALL implement FSM states IDLE, LOAD_A, LOAD_B, WAIT_DONE, RELEASE.
REQ-018 SHALL transition IDLE->LOAD_A when the FIFO is non-empty and mul_done==0, popping the head into hold registers on that edge.
REQ-019 SHALL transition LOAD_A->LOAD_B unconditionally and LOAD_B->WAIT_DONE unconditionally.
REQ-020 SHALL transition WAIT_DONE->RELEASE when mul_done==1, and otherwise remain in WAIT_DONE.
REQ-021 SHALL transition RELEASE->IDLE unconditionally.
REQ-022 SHALL ignore mul_done while in IDLE, LOAD_A, LOAD_B, or RELEASE.
REQ-023 SHALL drive mul_start=1 in LOAD_A, LOAD_B, and WAIT_DONE, and 0 in IDLE and RELEASE; mul_start and mul_data SHALL be registered outputs.
REQ-024 SHALL drive mul_data as hold_a in LOAD_A, hold_b in LOAD_B and WAIT_DONE, and 0 in IDLE and RELEASE.
REQ-025 SHALL produce its first LOAD_A cycle 2 cycles after the push edge when a pair arrives into an empty FIFO with the FSM in IDLE.
REQ-026 SHALL increment issued_count on the WAIT_DONE->RELEASE edge, wrapping 255->0.
REQ-027 SHALL issue mul_b=0 operands normally and wait for mul_done; no special-casing.
REQ-028 SHALL set a minimum pair-to-pair issue spacing of 5 cycles for back-to-back pairs with mul_done asserted one cycle into WAIT_DONE.

Reset
REQ-029 SHALL, with rst high at a clock edge, set state to IDLE, FIFO empty, in_ready=1, mul_start=0, mul_data=0, busy=0, issued_count=0, and hold registers 0.
REQ-030 SHALL, on rst in any state including mid-WAIT_DONE, abort the operation and drop all FIFO contents; no partial pair is later issued.
REQ-031 SHALL give rst priority over push and pop in the same cycle.

Structure
REQ-032 SHALL place the FSM state encoding (3-bit, IDLE=0 through RELEASE=4) and the WIDTH and DEPTH defaults in a shared package, mul_pkg.
REQ-033 SHALL use one sub-module, mul_pair_fifo, parameterized by WIDTH and DEPTH, storing {a,b} as 2*WIDTH bits; the FSM stays in the top level.

Verification
REQ-034 SHALL cover single pair: push (17,5) into an idle, empty block -> mul_data shows 17 then 5 on consecutive cycles with mul_start high; mul_done pulse -> mul_start low for 1 cycle; issued_count=1.
REQ-035 SHALL cover full FIFO: 3 pushes while WAIT_DONE is stalled -> in_ready=0 after the 2nd stored pair and the 3rd pair is not accepted until a pop.
REQ-036 SHALL cover back-to-back: pairs (3,4),(6,7) with mul_done after 1 WAIT_DONE cycle -> second LOAD_A exactly 5 cycles after the first.
REQ-037 SHALL cover stuck done: mul_done held high through RELEASE -> FSM stays IDLE until mul_done falls, then issues the next pair.
REQ-038 SHALL cover reset mid-op: rst during WAIT_DONE with 1 pair queued -> next cycle all outputs at reset values, and no issue occurs afterward without a new push.
REQ-039 SHALL cover count wrap: 256 completed operations -> issued_count returns to 0.
